// File: rtl/exec_if.sv
// Execute-stage handshake bundle: issue side (in_*) and result side (out_*).
interface exec_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [XLEN-1:0] in_imm;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [4:0]      out_rd;
  logic            out_br_taken;
  logic [XLEN-1:0] out_br_target;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_op, in_a, in_b,
    input  in_imm, in_pc, in_rd,
    output in_ready,
    output out_valid, out_result, out_rd,
    output out_br_taken, out_br_target,
    output out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_a, in_b,
    output in_imm, in_pc, in_rd,
    input  in_ready,
    input  out_valid, out_result, out_rd,
    input  out_br_taken, out_br_target,
    input  out_illegal,
    output out_ready
  );
endinterface

// File: rtl/exec_unit.sv
// RV32I/RV64I execute stage; define EXEC_MEXT_EN to add the
// 2-cycle multiplier and iterative divider (MUL/DIV/FIX states).
module exec_unit #(
  parameter int              XLEN     = 32,
  parameter int              SHAMT_W  = 5,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  output logic  busy,
  exec_if.slave io
);
  typedef logic [XLEN-1:0] word_t;
  localparam word_t FOUR = word_t'(4);

  word_t              a, b, pc_imm;
  word_t              alu_res, alu_tgt;
  logic [SHAMT_W-1:0] shamt;
  logic               alu_taken, alu_ill;
  logic               can_out, accept;
  logic               idle, is_multi;
  logic               ld_fsm;
  word_t              fsm_res;
  logic [4:0]         fsm_rd;

  assign a      = io.in_a;
  assign b      = io.in_b;
  assign shamt  = b[SHAMT_W-1:0];
  assign pc_imm = io.in_pc + io.in_imm;

  assign can_out     = !io.out_valid || io.out_ready;
  assign io.in_ready = idle && can_out && !flush;
  assign accept      = io.in_valid && io.in_ready;
  assign busy        = !idle;

  always_comb begin
    alu_res   = '0;
    alu_tgt   = pc_imm;
    alu_taken = 1'b0;
    alu_ill   = 1'b0;
    case (io.in_op)
      5'd0:  alu_res = a + b;
      5'd1:  alu_res = a - b;
      5'd2:  alu_res = a << shamt;
      5'd3:  alu_res = word_t'($signed(a) < $signed(b));
      5'd4:  alu_res = word_t'(a < b);
      5'd5:  alu_res = a ^ b;
      5'd6:  alu_res = a >> shamt;
      5'd7:  alu_res = word_t'($signed(a) >>> shamt);
      5'd8:  alu_res = a | b;
      5'd9:  alu_res = a & b;
      5'd10: alu_res = b;
      5'd11: alu_res = io.in_pc + b;
      5'd12: begin
        alu_res   = io.in_pc + FOUR;
        alu_taken = 1'b1;
      end
      5'd13: begin
        alu_res   = io.in_pc + FOUR;
        alu_tgt   = (a + io.in_imm) & ~word_t'(1);
        alu_taken = 1'b1;
      end
      5'd14: alu_taken = (a == b);
      5'd15: alu_taken = (a != b);
      5'd16: alu_taken = ($signed(a) < $signed(b));
      5'd17: alu_taken = ($signed(a) >= $signed(b));
      5'd18: alu_taken = (a < b);
      5'd19: alu_taken = (a >= b);
      5'd20: alu_res = a + b;
      default: alu_ill = 1'b1;
    endcase
  end

`ifdef EXEC_MEXT_EN
  typedef enum logic [1:0] {
    S_IDLE, S_MUL, S_DIV, S_FIX
  } state_t;
  localparam int    CW      = $clog2(XLEN);
  localparam word_t MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nx;
  logic [CW-1:0]     cnt;
  word_t             acc, quo, rem, dvs;
  word_t             a_mag, b_mag, mul_val, fix_val;
  word_t             rem_nx, quo_nx, q_fin, r_fin;
  logic [2*XLEN-1:0] ma, mb, prod;
  logic [XLEN:0]     rs, df;
  logic              neg_q, neg_r, is_rem;
  logic              sgn, rem_op, a_neg, b_neg;
  logic              is_mul, div0, ovf;
  logic [4:0]        rd_q;

  assign idle     = (state == S_IDLE);
  assign is_multi = (io.in_op >= 5'd21) && (io.in_op <= 5'd28);
  assign is_mul   = (io.in_op >= 5'd21) && (io.in_op <= 5'd24);
  assign sgn      = (io.in_op == 5'd25) || (io.in_op == 5'd27);
  assign rem_op   = (io.in_op == 5'd27) || (io.in_op == 5'd28);
  assign a_neg    = sgn && a[XLEN-1];
  assign b_neg    = sgn && b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;
  assign div0     = (b == '0);
  assign ovf      = sgn && (a == MIN_NEG) && (b == '1);
  assign fix_val  = div0 ? (rem_op ? a : '1)
                         : (rem_op ? '0 : a);

  // Sign/zero-extend to 2*XLEN so one unsigned multiply serves all four ops.
  assign ma = (io.in_op == 5'd22 || io.in_op == 5'd23)
            ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
  assign mb = (io.in_op == 5'd22)
            ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
  assign prod    = ma * mb;
  assign mul_val = (io.in_op == 5'd21) ? prod[XLEN-1:0]
                                       : prod[2*XLEN-1:XLEN];

  assign rs     = {rem, quo[XLEN-1]};
  assign df     = rs - {1'b0, dvs};
  assign rem_nx = df[XLEN] ? rs[XLEN-1:0] : df[XLEN-1:0];
  assign quo_nx = {quo[XLEN-2:0], ~df[XLEN]};
  assign q_fin  = neg_q ? -quo_nx : quo_nx;
  assign r_fin  = neg_r ? -rem_nx : rem_nx;
  assign fsm_rd = rd_q;

  always_comb begin
    state_nx = state;
    ld_fsm   = 1'b0;
    fsm_res  = acc;
    case (state)
      S_IDLE: if (accept && is_multi)
        state_nx = is_mul ? S_MUL
                 : (div0 || ovf) ? S_FIX : S_DIV;
      S_MUL, S_FIX: if (can_out) begin
        ld_fsm   = 1'b1;
        state_nx = S_IDLE;
      end
      S_DIV: if (cnt == '0 && can_out) begin
        ld_fsm   = 1'b1;
        fsm_res  = is_rem ? r_fin : q_fin;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (flush) begin
      state_nx = S_IDLE;
      ld_fsm   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // The last iteration is folded into the output write, so cnt==0 never steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
      rd_q   <= '0;
    end else if (accept && is_multi) begin
      acc    <= is_mul ? mul_val : fix_val;
      quo    <= a_mag;
      rem    <= '0;
      dvs    <= b_mag;
      cnt    <= CW'(XLEN-1);
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      is_rem <= rem_op;
      rd_q   <= io.in_rd;
    end else if (state == S_DIV && cnt != '0 && !flush) begin
      quo <= quo_nx;
      rem <= rem_nx;
      cnt <= cnt - 1'b1;
    end
  end
`else
  assign idle     = 1'b1;
  assign is_multi = 1'b0;
  assign ld_fsm   = 1'b0;
  assign fsm_res  = '0;
  assign fsm_rd   = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.out_valid     <= 1'b0;
      io.out_result    <= '0;
      io.out_rd        <= '0;
      io.out_br_taken  <= 1'b0;
      io.out_br_target <= RESET_PC;
      io.out_illegal   <= 1'b0;
    end else if (flush) begin
      io.out_valid <= 1'b0;
    end else if (accept && !is_multi) begin
      io.out_valid     <= 1'b1;
      io.out_result    <= alu_res;
      io.out_rd        <= io.in_rd;
      io.out_br_taken  <= alu_taken;
      io.out_br_target <= alu_tgt;
      io.out_illegal   <= alu_ill;
    end else if (ld_fsm) begin
      io.out_valid    <= 1'b1;
      io.out_result   <= fsm_res;
      io.out_rd       <= fsm_rd;
      io.out_br_taken <= 1'b0;
      io.out_illegal  <= 1'b0;
    end else if (io.out_ready) begin
      io.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: vector table, scoreboard
// queue and hand-written handshake/flush/latency sequences.
module tb_exec_unit;
  localparam int          XLEN = 32;
  localparam logic [31:0] RPC  = 32'h0000_0080;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, imm, pc;
    logic [31:0] res;
    logic        tk, ct;
    logic [31:0] tgt;
    logic        ill;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        tk, ct;
    logic [31:0] tgt;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t sb[$];
  exp_t me;

  exec_if #(.XLEN(XLEN)) io ();

  exec_unit #(
    .XLEN(XLEN), .SHAMT_W(5), .RESET_PC(RPC)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .busy(busy), .io(io.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    logic [4:0] op, logic [31:0] a, b, imm, pc, res,
    logic tk, ct, logic [31:0] tgt, logic ill, int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
    v.res = res; v.tk = tk; v.ct = ct; v.tgt = tgt;
    v.ill = ill; v.lat = lat;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && io.out_valid && io.out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        me = sb.pop_front();
        chk("out_result", io.out_result, me.res);
        chk("out_rd", io.out_rd, me.rd);
        chk("out_br_taken", io.out_br_taken, me.tk);
        chk("out_illegal", io.out_illegal, me.ill);
        if (me.ct) chk("out_br_target", io.out_br_target, me.tgt);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(vec_t v, logic [4:0] rd, bit push);
    exp_t e;
    int   n = 0;
    bit   ok = 1'b0;
    io.in_valid = 1'b1;
    io.in_op = v.op;
    io.in_a = v.a;
    io.in_b = v.b;
    io.in_imm = v.imm;
    io.in_pc = v.pc;
    io.in_rd = rd;
    if (push) begin
      e.res = v.res; e.rd = rd; e.tk = v.tk;
      e.ct = v.ct; e.tgt = v.tgt; e.ill = v.ill;
      sb.push_back(e);
    end
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = io.in_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) chk("issue_timeout", 0, 1);
    #1 io.in_valid = 1'b0;
  endtask

  task automatic run_lat(vec_t v);
    int n = 1;
    issue(v, 5'd9, 1'b1);
    @(negedge clk);
    while (!io.out_valid && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("latency_op%0d", v.op), n, v.lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[23];
    vec_t mt[$];
    int   c0;
    io.in_valid = 1'b0; io.in_op = '0; io.in_a = '0;
    io.in_b = '0; io.in_imm = '0; io.in_pc = '0;
    io.in_rd = '0; io.out_ready = 1'b1;

    tbl[0]  = mk(0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(7, 32'h80000000, 4, 0, 0, 32'hF8000000, 0, 0, 0, 0, 1);
    tbl[2]  = mk(7, 32'h7FFFFFF0, 4, 0, 0, 32'h07FFFFFF, 0, 0, 0, 0, 1);
    tbl[3]  = mk(1, 5, 7, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 0, 1);
    tbl[4]  = mk(2, 1, 32'h21, 0, 0, 2, 0, 0, 0, 0, 1);
    tbl[5]  = mk(3, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    tbl[6]  = mk(4, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(5, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0,
                 32'h0FF00FF0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(6, 32'h80000000, 4, 0, 0, 32'h08000000, 0, 0, 0, 0, 1);
    tbl[9]  = mk(8, 32'h0F00, 32'h00F0, 0, 0, 32'h0FF0, 0, 0, 0, 0, 1);
    tbl[10] = mk(9, 32'hF0F0F0F0, 32'hFF00FF00, 0, 0,
                 32'hF000F000, 0, 0, 0, 0, 1);
    tbl[11] = mk(10, 0, 32'h12345000, 0, 0, 32'h12345000, 0, 0, 0, 0, 1);
    tbl[12] = mk(11, 0, 32'h2000, 0, 32'h1000, 32'h3000, 0, 0, 0, 0, 1);
    tbl[13] = mk(12, 0, 0, 32'h20, 32'h100, 32'h104, 1, 1, 32'h120, 0, 1);
    tbl[14] = mk(13, 32'h201, 0, 0, 32'h40, 32'h44, 1, 1, 32'h200, 0, 1);
    tbl[15] = mk(16, 32'hFFFFFFFF, 1, 32'hFFFFFFF8, 32'h100,
                 0, 1, 1, 32'hF8, 0, 1);
    tbl[16] = mk(14, 5, 6, 32'h10, 32'h200, 0, 0, 1, 32'h210, 0, 1);
    tbl[17] = mk(15, 5, 6, 4, 32'h300, 0, 1, 1, 32'h304, 0, 1);
    tbl[18] = mk(17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h10, 0,
                 0, 1, 1, 32'h10, 0, 1);
    tbl[19] = mk(19, 1, 32'hFFFFFFFF, 8, 0, 0, 0, 1, 8, 0, 1);
    tbl[20] = mk(18, 1, 32'hFFFFFFFF, 32'hC, 0, 0, 1, 1, 32'hC, 0, 1);
    tbl[21] = mk(20, 32'h1000, 32'h24, 0, 0, 32'h1024, 0, 0, 0, 0, 1);
    tbl[22] = mk(30, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1);

`ifdef EXEC_MEXT_EN
    mt.push_back(mk(21, 3, 4, 0, 0, 12, 0, 0, 0, 0, 2));
    mt.push_back(mk(22, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 2));
    mt.push_back(mk(22, 32'h80000000, 32'h80000000, 0, 0,
                    32'h40000000, 0, 0, 0, 0, 2));
    mt.push_back(mk(23, 32'hFFFFFFFF, 2, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 2));
    mt.push_back(mk(24, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0,
                    32'hFFFFFFFE, 0, 0, 0, 0, 2));
    mt.push_back(mk(25, 32'hFFFFFFF9, 2, 0, 0, 32'hFFFFFFFD, 0, 0, 0, 0, 33));
    mt.push_back(mk(27, 32'hFFFFFFF9, 2, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 33));
    mt.push_back(mk(25, 7, 32'hFFFFFFFE, 0, 0, 32'hFFFFFFFD, 0, 0, 0, 0, 33));
    mt.push_back(mk(27, 7, 32'hFFFFFFFE, 0, 0, 1, 0, 0, 0, 0, 33));
    mt.push_back(mk(26, 100, 7, 0, 0, 14, 0, 0, 0, 0, 33));
    mt.push_back(mk(28, 100, 7, 0, 0, 2, 0, 0, 0, 0, 33));
    mt.push_back(mk(26, 5, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 2));
    mt.push_back(mk(28, 5, 0, 0, 0, 5, 0, 0, 0, 0, 2));
    mt.push_back(mk(25, 32'h80000000, 32'hFFFFFFFF, 0, 0,
                    32'h80000000, 0, 0, 0, 0, 2));
    mt.push_back(mk(27, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 2));
`else
    mt.push_back(mk(21, 3, 4, 0, 0, 0, 0, 0, 0, 1, 1));
    mt.push_back(mk(25, 32'hFFFFFFF9, 2, 0, 0, 0, 0, 0, 0, 1, 1));
    mt.push_back(mk(28, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1));
`endif
    mt.push_back(mk(31, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1));

    #12;
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_result", io.out_result, 0);
    chk("rst_out_rd", io.out_rd, 0);
    chk("rst_br_taken", io.out_br_taken, 0);
    chk("rst_br_target", io.out_br_target, RPC);
    chk("rst_illegal", io.out_illegal, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", io.in_ready, 1);
    @(posedge clk); #1;

    c0 = cyc;
    for (int i = 0; i < 23; i++) issue(tbl[i], 5'(i + 1), 1'b1);
    chk("throughput_cycles", cyc - c0, 23);
    @(posedge clk); #1;

    foreach (mt[i]) run_lat(mt[i]);
    @(posedge clk); #1;

    io.out_ready = 1'b0;
    issue(mk(0, 10, 20, 0, 0, 30, 0, 0, 0, 0, 1), 5'd7, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", io.out_valid, 1);
      chk("bp_result", io.out_result, 30);
      chk("bp_in_ready", io.in_ready, 0);
    end
    @(posedge clk); #1 io.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", io.in_ready, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_valid_clear", io.out_valid, 0);
    @(posedge clk); #1;

    io.out_ready = 1'b0;
    issue(mk(0, 1, 2, 0, 0, 3, 0, 0, 0, 0, 1), 5'd3, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", io.in_ready, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_kill_valid", io.out_valid, 0);
    @(posedge clk); #1 io.out_ready = 1'b1;

    io.in_valid = 1'b1; io.in_op = 5'd0;
    io.in_a = 32'h5; io.in_b = 32'h6; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; io.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_drop_valid", io.out_valid, 0);
    @(posedge clk); #1;

`ifdef EXEC_MEXT_EN
    issue(mk(25, 100, 7, 0, 0, 0, 0, 0, 0, 0, 33), 5'd4, 1'b0);
    @(negedge clk);
    chk("div_busy", busy, 1);
    chk("div_stall", io.in_ready, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("div_flush_busy", busy, 0);
    chk("div_flush_valid", io.out_valid, 0);
    repeat (40) @(negedge clk);
    chk("div_flush_no_out", io.out_valid, 0);
    @(posedge clk); #1;

    issue(mk(26, 100, 7, 0, 0, 0, 0, 0, 0, 0, 33), 5'd4, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("div_rst_busy", busy, 0);
    chk("div_rst_valid", io.out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("div_rst_no_out", io.out_valid, 0);
    @(posedge clk); #1;
    run_lat(mk(26, 100, 7, 0, 0, 14, 0, 0, 0, 0, 33));
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
